alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer_pkg.sv | 24 ++
 rtl/alu_cmd_issuer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer_pkg.sv
`timescale 1ns/1ps
// Shared types and widths for the ALU command issuer.
package alu_cmd_issuer_pkg;

  localparam int          ALU_W              = 32;
  localparam int          OP_W               = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [OP_W-1:0]  op;
    logic             inc;
    logic             inv;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_issuer.sv
`timescale 1ns/1ps
// Issues one command at a time to a restartable ALU and holds its result until consumed.
// Latency: LAUNCH_CYCLES + k + 1 cycles from accept to rsp_valid_o; cmd_ready_o is low until the response is taken.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned LAUNCH_CYCLES  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [ALU_W-1:0] cmd_a_i,
  input  logic [ALU_W-1:0] cmd_b_i,
  input  logic [OP_W-1:0]  cmd_aluop_i,
  input  logic             cmd_inc_i,
  input  logic             cmd_inv_i,
  output logic [ALU_W-1:0] alu_a_o,
  output logic [ALU_W-1:0] alu_b_o,
  output logic [OP_W-1:0]  alu_aluop_o,
  output logic             alu_output_inc_o,
  output logic             alu_output_inverted_o,
  output logic             alu_rst_o,
  input  logic             alu_done_i,
  input  logic [ALU_W-1:0] alu_res_high_i,
  input  logic [ALU_W-1:0] alu_res_low_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [ALU_W-1:0] rsp_high_o,
  output logic [ALU_W-1:0] rsp_low_o,
  output logic             rsp_timeout_o
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LCNT_W = $clog2(LAUNCH_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [LCNT_W-1:0] LCNT_LAST  = LCNT_W'(LAUNCH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cmd_t               cmd_q, cmd_d;
  logic [ALU_W-1:0]   rsp_high_q, rsp_high_d;
  logic [ALU_W-1:0]   rsp_low_q, rsp_low_d;
  logic               rsp_to_q, rsp_to_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      lcnt_q     <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      rsp_high_q <= '0;
      rsp_low_q  <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lcnt_q     <= lcnt_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      rsp_high_q <= rsp_high_d;
      rsp_low_q  <= rsp_low_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    rsp_high_d = rsp_high_q;
    rsp_low_d  = rsp_low_q;
    rsp_to_d   = rsp_to_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d   = '{a: cmd_a_i, b: cmd_b_i, op: cmd_aluop_i, inc: cmd_inc_i, inv: cmd_inv_i};
          lcnt_d  = '0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (lcnt_q == LCNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // cnt_q == 0 is the settle cycle right after restart; done is not trusted there.
        if (alu_done_i && (cnt_q != '0)) begin
          rsp_high_d = alu_res_high_i;
          rsp_low_d  = alu_res_low_i;
          rsp_to_d   = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q >= CNT_LAST) begin
          rsp_high_d = '0;
          rsp_low_d  = '0;
          rsp_to_d   = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready_o           = (state_q == ST_IDLE);
  assign alu_rst_o             = (state_q == ST_LAUNCH);
  assign rsp_valid_o           = (state_q == ST_RESP);
  assign alu_a_o               = cmd_q.a;
  assign alu_b_o               = cmd_q.b;
  assign alu_aluop_o           = cmd_q.op;
  assign alu_output_inc_o      = cmd_q.inc;
  assign alu_output_inverted_o = cmd_q.inv;
  assign rsp_high_o            = rsp_high_q;
  assign rsp_low_o             = rsp_low_q;
  assign rsp_timeout_o         = rsp_to_q;

endmodule
